// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and the memory.
//   req  : read request, held high until ack
//   addr : word address, stable while req is high (except on a squashing redirect)
//   ack  : memory returns data this cycle
//   data : instruction word, valid only with ack
// The master modport is the fetch unit; the slave modport is the memory.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage. Owns the PC, issues one read at a time over the
// req/ack memory port and hands each fetched word to the datapath IR with a one-cycle
// write pulse. Control may redirect the PC at any time; a redirect squashes a fetch
// that is still in flight.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   fetch_en_i     request the next instruction (only honoured while idle)
//   redirect_i     load PC from redirect_pc_i; highest priority in every state
//   redirect_pc_i  branch/jump target
//   im             instruction-memory port (master side)
//   ir_data_o      last delivered instruction word
//   ir_wrt_o       one-cycle pulse: ir_data_o valid, load IR
//   pc_out_o       address of the instruction on ir_data_o
//   busy_o         high whenever a fetch is in progress
module instr_fetch_unit #(
  parameter int unsigned      ADDR_W   = 16,
  parameter int unsigned      DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_en_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  instr_fetch_unit_if.master  im,
  output logic [DATA_W-1:0]   ir_data_o,
  output logic                ir_wrt_o,
  output logic [ADDR_W-1:0]   pc_out_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    StWait = 2'b00,
    StReq  = 2'b01,
    StDlvr = 2'b10
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                squash_q;
  logic                im_req_q;
  logic [DATA_W-1:0]   ir_data_q;
  logic                ir_wrt_q;
  logic [ADDR_W-1:0]   pc_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StWait;
      pc_q      <= RESET_PC;
      squash_q  <= 1'b0;
      im_req_q  <= 1'b0;
      ir_data_q <= '0;
      ir_wrt_q  <= 1'b0;
      pc_out_q  <= '0;
    end else begin
      unique case (state_q)
        StWait: begin
          ir_wrt_q <= 1'b0;
          // Late acks from a fetch killed by reset land here and are dropped.
          if (redirect_i) begin
            pc_q <= redirect_pc_i;
          end
          if (fetch_en_i) begin
            state_q  <= StReq;
            im_req_q <= 1'b1;
          end
        end

        StReq: begin
          if (im.ack) begin
            if (squash_q || redirect_i) begin
              // Data belongs to a stale address: drop it and re-request at the
              // current PC, keeping req high so the new read goes out immediately.
              squash_q <= 1'b0;
              if (redirect_i) begin
                pc_q <= redirect_pc_i;
              end
            end else begin
              ir_data_q <= im.data;
              pc_out_q  <= pc_q;
              im_req_q  <= 1'b0;
              ir_wrt_q  <= 1'b1;
              state_q   <= StDlvr;
            end
          end else if (redirect_i) begin
            // The memory may already be working on the old address, so its ack
            // must be discarded when it eventually arrives.
            pc_q     <= redirect_pc_i;
            squash_q <= 1'b1;
          end
        end

        StDlvr: begin
          ir_wrt_q <= 1'b0;
          state_q  <= StWait;
          if (redirect_i) begin
            pc_q <= redirect_pc_i;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end

        default: begin
          state_q  <= StWait;
          im_req_q <= 1'b0;
          ir_wrt_q <= 1'b0;
          squash_q <= 1'b0;
        end
      endcase
    end
  end

  assign im.req    = im_req_q;
  assign im.addr   = pc_q;
  assign ir_data_o = ir_data_q;
  assign pc_out_o  = pc_out_q;
  assign busy_o    = (state_q != StWait);

  // The write pulse is registered, but a redirect arriving during the delivery cycle
  // must still cancel it, so it is gated by the live redirect input.
  assign ir_wrt_o  = ir_wrt_q & ~redirect_i;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ir_data;
  logic        ir_wrt;
  logic [15:0] pc_out;
  logic        busy;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) im_bus ();

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .im            (im_bus),
    .ir_data_o     (ir_data),
    .ir_wrt_o      (ir_wrt),
    .pc_out_o      (pc_out),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  // Scoreboard monitor: every IR write must match the oldest expected delivery.
  always @(negedge clk) begin
    if (rst_n && ir_wrt) begin
      if (exp_q.size() == 0) begin
        chk("spurious_irwrt", {16'h0, ir_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ir_data", {16'h0, ir_data}, {16'h0, e.data});
        chk("pc_out", {16'h0, pc_out}, {16'h0, e.pc});
      end
    end
  end

  // One complete fetch as seen from control and memory. Optional events: redirect with
  // fetchEn, squashing redirect at wait cycle sq_at, redirect coincident with the
  // first ack, redirect in the delivery cycle.
  task automatic fetch_episode(input bit wr, input logic [15:0] wpc, input int waits,
                               input int sq_at, input logic [15:0] sq_pc,
                               input bit co, input logic [15:0] co_pc,
                               input bit dr, input logic [15:0] dr_pc,
                               input logic [15:0] data, input logic [15:0] junk);
    bit squash;
    bit discard;
    squash      = 1'b0;
    fetch_en    = 1'b1;
    redirect    = wr;
    redirect_pc = wpc;
    if (wr) model_pc = wpc;
    tick();
    fetch_en = 1'b0;
    redirect = 1'b0;
    chk("req_issued", 32'(im_bus.req), 32'd1);
    chk("req_addr", 32'(im_bus.addr), 32'(model_pc));
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < waits; i++) begin
        if (a == 0 && i == sq_at) begin
          redirect    = 1'b1;
          redirect_pc = sq_pc;
          model_pc    = sq_pc;
          squash      = 1'b1;
        end
        tick();
        redirect = 1'b0;
        chk("req_held", 32'(im_bus.req), 32'd1);
        chk("addr_held", 32'(im_bus.addr), 32'(model_pc));
      end
      discard = squash;
      if (a == 0 && co) begin
        redirect    = 1'b1;
        redirect_pc = co_pc;
        model_pc    = co_pc;
        discard     = 1'b1;
      end
      im_bus.ack  = 1'b1;
      im_bus.data = discard ? junk : data;
      tick();
      im_bus.ack  = 1'b0;
      im_bus.data = 16'($urandom);
      redirect    = 1'b0;
      if (!discard) break;
      squash = 1'b0;
      chk("req_reissue", 32'(im_bus.req), 32'd1);
      chk("reissue_addr", 32'(im_bus.addr), 32'(model_pc));
    end
    chk("busy_dlvr", 32'(busy), 32'd1);
    chk("req_drop", 32'(im_bus.req), 32'd0);
    fetch_en = 1'($urandom_range(0, 1));
    if (dr) begin
      redirect    = 1'b1;
      redirect_pc = dr_pc;
    end else begin
      exp_q.push_back('{data: data, pc: model_pc});
    end
    tick();
    fetch_en = 1'b0;
    redirect = 1'b0;
    model_pc = dr ? dr_pc : model_pc + 16'd1;
    chk("delivered", 32'(exp_q.size()), 32'd0);
    chk("busy_wait", 32'(busy), 32'd0);
    chk("req_idle", 32'(im_bus.req), 32'd0);
    chk("next_addr", 32'(im_bus.addr), 32'(model_pc));
  endtask

  // Idle cycles: stray acks must be ignored, a bare redirect just moves the PC.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      redirect    = ($urandom_range(0, 3) == 0);
      redirect_pc = rand_pc();
      if (redirect) model_pc = redirect_pc;
      im_bus.ack  = 1'($urandom_range(0, 1));
      im_bus.data = 16'($urandom);
      tick();
      chk("idle_req", 32'(im_bus.req), 32'd0);
      chk("idle_addr", 32'(im_bus.addr), 32'(model_pc));
      chk("idle_busy", 32'(busy), 32'd0);
    end
    redirect   = 1'b0;
    im_bus.ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    im_bus.ack  = 1'b0;
    im_bus.data = '0;
    model_pc    = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(im_bus.req), 32'd0);
    chk("rst_addr", 32'(im_bus.addr), 32'(RESET_PC));
    chk("rst_irdata", 32'(ir_data), 32'd0);
    chk("rst_irwrt", 32'(ir_wrt), 32'd0);
    chk("rst_pcout", 32'(pc_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // First fetch, zero wait states.
    fetch_episode(0, 0, 0, -1, 0, 0, 0, 0, 0, 16'h1234, 0);
    // Three wait states.
    fetch_episode(0, 0, 3, -1, 0, 0, 0, 0, 0, 16'hA5A5, 0);
    // Redirect together with fetchEn, then sequential follow-up.
    fetch_episode(1, 16'h0040, 0, -1, 0, 0, 0, 0, 0, 16'h1111, 0);
    fetch_episode(0, 0, 1, -1, 0, 0, 0, 0, 0, 16'h2222, 0);
    // Squash: in flight at 5, redirected to 0100, stale DEAD dropped.
    fetch_episode(1, 16'h0005, 2, 1, 16'h0100, 0, 0, 0, 0, 16'h3333, 16'hDEAD);
    // Redirect coincident with ack, then redirect during delivery.
    fetch_episode(0, 0, 1, -1, 0, 1, 16'h0200, 0, 0, 16'h4444, 16'hBAD0);
    fetch_episode(0, 0, 0, -1, 0, 0, 0, 1, 16'h0300, 16'h5555, 0);
    fetch_episode(0, 0, 0, -1, 0, 0, 0, 0, 0, 16'h6666, 0);
    // PC wrap.
    fetch_episode(1, 16'hFFFF, 0, -1, 0, 0, 0, 0, 0, 16'h7777, 0);

    // Async reset in the middle of a request.
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("pre_rst_req", 32'(im_bus.req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(im_bus.req), 32'd0);
    chk("async_addr", 32'(im_bus.addr), 32'(RESET_PC));
    chk("async_busy", 32'(busy), 32'd0);
    im_bus.ack  = 1'b1;
    im_bus.data = 16'hBEEF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    im_bus.ack = 1'b0;
    model_pc   = RESET_PC;
    chk("post_rst_req", 32'(im_bus.req), 32'd0);
    chk("post_rst_irdata", 32'(ir_data), 32'd0);
    chk("post_rst_pcout", 32'(pc_out), 32'd0);
    chk("post_rst_addr", 32'(im_bus.addr), 32'(model_pc));
    fetch_episode(0, 0, 1, -1, 0, 0, 0, 0, 0, 16'h8888, 0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int w;
      w = $urandom_range(0, 3);
      fetch_episode(($urandom_range(0, 3) == 0), rand_pc(), w,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1, rand_pc(),
                    ($urandom_range(0, 5) == 0), rand_pc(),
                    ($urandom_range(0, 5) == 0), rand_pc(),
                    16'($urandom), 16'($urandom));
      idle($urandom_range(0, 2));
    end

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
